// File: rtl/stat_bcd_scheduler.sv
// Serial double-dabble converter time-shared among four statistics counters.
// Results are held per channel for the display mux; channels rotate round-robin unless one is forced.
module stat_bcd_scheduler #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [BIN_W-1:0]      cnt0,
    input  logic [BIN_W-1:0]      cnt1,
    input  logic [BIN_W-1:0]      cnt2,
    input  logic [BIN_W-1:0]      cnt3,
    input  logic                  force_req,
    input  logic [1:0]            force_ch,
    output logic [4*DIGITS-1:0]   bcd0,
    output logic [4*DIGITS-1:0]   bcd1,
    output logic [4*DIGITS-1:0]   bcd2,
    output logic [4*DIGITS-1:0]   bcd3,
    output logic [3:0]            ovf,
    output logic [3:0]            valid,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            done_ch
);

    // At least one digit above DIGITS is kept so that overflow is always detectable.
    localparam int NAT_D = (BIN_W + 2) / 3;
    localparam int XD    = (NAT_D > DIGITS) ? NAT_D : DIGITS + 1;
    localparam int XW    = 4 * XD;
    localparam int RW    = 4 * DIGITS;
    localparam int CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [1:0]       rr_q, rr_d;
    logic             pend_q, pend_d;
    logic [1:0]       pend_ch_q, pend_ch_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [XW-1:0]    dd_q, dd_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [RW-1:0]    bcd_q [4];
    logic [RW-1:0]    bcd_d [4];
    logic [3:0]       ovf_q, ovf_d;
    logic [3:0]       valid_q, valid_d;

    logic [BIN_W-1:0] cnt_sel;
    logic [XW-1:0]    dd_adj;
    logic [XW-1:0]    dd_shift;
    logic [BIN_W-1:0] bin_shift;
    logic             hi_nz;
    logic [RW-1:0]    result;

    always_comb begin
        cnt_sel = cnt0;
        case (ch_q)
            2'd0: cnt_sel = cnt0;
            2'd1: cnt_sel = cnt1;
            2'd2: cnt_sel = cnt2;
            2'd3: cnt_sel = cnt3;
            default: cnt_sel = cnt0;
        endcase
    end

    // Add-3 correction on every digit, then one combined left shift of {bcd, bin}.
    always_comb begin
        dd_adj = '0;
        for (int i = 0; i < XD; i++) begin
            if (dd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_q[4*i +: 4] + 4'd3;
            else                        dd_adj[4*i +: 4] = dd_q[4*i +: 4];
        end
        dd_shift  = {dd_adj[XW-2:0], bin_q[BIN_W-1]};
        bin_shift = {bin_q[BIN_W-2:0], 1'b0};
        hi_nz     = |dd_shift[XW-1:RW];
        result    = hi_nz ? {DIGITS{4'h9}} : dd_shift[RW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        pend_d    = pend_q;
        pend_ch_d = pend_ch_q;
        bin_d     = bin_q;
        dd_d      = dd_q;
        bit_d     = bit_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;

        case (state_q)
            IDLE, STORE: begin
                state_d = IDLE;
                if (en) begin
                    state_d = LOAD;
                    ch_d    = pend_q ? pend_ch_q : rr_q;
                    rr_d    = ch_d + 2'd1;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                bin_d   = cnt_sel;
                dd_d    = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                dd_d  = dd_shift;
                bin_d = bin_shift;
                bit_d = bit_q + CW'(1);
                // The final shift lands directly in the output register so the result is visible during STORE.
                if (bit_q == CW'(BIN_W - 1)) begin
                    state_d       = STORE;
                    bcd_d[ch_q]   = result;
                    ovf_d[ch_q]   = hi_nz;
                    valid_d[ch_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A request arriving in a pick cycle survives the clear and applies to the next pick.
        if (force_req) begin
            pend_d    = 1'b1;
            pend_ch_d = force_ch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= 2'd0;
            rr_q      <= 2'd0;
            pend_q    <= 1'b0;
            pend_ch_q <= 2'd0;
            bin_q     <= '0;
            dd_q      <= '0;
            bit_q     <= '0;
            for (int i = 0; i < 4; i++) bcd_q[i] <= '0;
            ovf_q     <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_q      <= rr_d;
            pend_q    <= pend_d;
            pend_ch_q <= pend_ch_d;
            bin_q     <= bin_d;
            dd_q      <= dd_d;
            bit_q     <= bit_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign bcd0    = bcd_q[0];
    assign bcd1    = bcd_q[1];
    assign bcd2    = bcd_q[2];
    assign bcd3    = bcd_q[3];
    assign ovf     = ovf_q;
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == STORE);
    assign done_ch = done ? ch_q : 2'd0;

endmodule
